// File: rtl/relu_stage_ctrl.sv
// rtl/relu_stage_ctrl.sv - activation-stage sequencer around an external reluArr
module relu_stage_ctrl #(
    parameter  int DATA_WIDTH = 8,
    parameter  int ARRAY_SIZE = 8,
    parameter  int CNT_WIDTH  = 10,
    localparam int ARR_W      = DATA_WIDTH * ARRAY_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    // layer command and status
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_rows,
    input  logic                 relu_cfg,
    output logic                 busy,
    output logic                 done,
    // rows from the systolic-array result path
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ARR_W-1:0]     in_data,
    // external reluArr instance
    output logic                 relu_en,
    output logic [ARR_W-1:0]     relu_in,
    input  logic [ARR_W-1:0]     relu_out,
    // rows towards the output buffer
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ARR_W-1:0]     out_data,
    output logic                 out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] rows_q;
    logic                 cfg_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic [ARR_W-1:0]     out_data_q;

    logic                 run_d;
    logic                 in_ready_d;
    logic                 accept_d;
    logic                 out_hs_d;
    logic                 last_row_d;
    logic [ARR_W-1:0]     row_d;

    // Handshake decode: one output register, so ready passes through when it empties this cycle
    always_comb begin
        run_d      = (state_q == S_RUN);
        in_ready_d = run_d && (!out_valid_q || out_ready);
        accept_d   = in_valid && in_ready_d;
        out_hs_d   = out_valid_q && out_ready;
        last_row_d = (cnt_q == (rows_q - CNT_ONE));
        // reluArr zeroes everything when disabled, so bypass has to select the raw row here
        row_d      = cfg_q ? relu_out : in_data;
    end

    assign in_ready  = in_ready_d;
    assign relu_en   = run_d && cfg_q;
    assign relu_in   = in_data;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

    // Layer FSM together with the output row register and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rows_q      <= '0;
            cfg_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (num_rows != '0) begin
                            rows_q  <= num_rows;
                            cfg_q   <= relu_cfg;
                            cnt_q   <= '0;
                            state_q <= S_RUN;
                        end else begin
                            // empty layer: report completion immediately
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (accept_d) begin
                        out_data_q  <= row_d;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_row_d;
                        cnt_q       <= cnt_q + CNT_ONE;
                        if (last_row_d) begin
                            state_q <= S_DRAIN;
                        end
                    end else if (out_hs_d) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // wait for the final row to leave before reporting completion
                    if (out_hs_d) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_stage_ctrl.sv
// tb/tb_relu_stage_ctrl.sv - scoreboard bench for relu_stage_ctrl
module tb_relu_stage_ctrl;

    localparam int DW = 8;
    localparam int AS = 8;
    localparam int CW = 10;
    localparam int AW = DW * AS;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_rows;
    logic          relu_cfg;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_data;
    logic          relu_en;
    logic [AW-1:0] relu_in;
    logic [AW-1:0] relu_out;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          out_last;

    always #5 clk = ~clk;

    relu_stage_ctrl #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .relu_cfg(relu_cfg), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .relu_en(relu_en), .relu_in(relu_in), .relu_out(relu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    // behavioural reluArr: positive elements pass when enabled, everything else is zero
    always_comb begin
        relu_out = '0;
        for (int i = 0; i < AS; i++) begin
            if (relu_en && ($signed(relu_in[i*DW +: DW]) > 0))
                relu_out[i*DW +: DW] = relu_in[i*DW +: DW];
        end
    end

    typedef struct {
        logic [AW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [AW-1:0] dir_q[$];

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            hs_cnt = 0;
    int            acc_idx = 0;
    int            cur_rows = 0;
    logic          cur_cfg = 1'b0;
    logic          chk_lat = 1'b0;
    int            last_acc_cyc = 0;
    int            done_cyc = 0;
    logic          stall = 1'b0;
    logic [AW-1:0] stall_data;
    logic          stall_last;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // expected row straight from the activation rule
    function automatic logic [AW-1:0] exp_row(input logic [AW-1:0] d, input logic cfg);
        logic [AW-1:0]        r;
        logic signed [DW-1:0] el;
        r = d;
        for (int i = 0; i < AS; i++) begin
            el = d[i*DW +: DW];
            if (cfg && el <= 0) r[i*DW +: DW] = '0;
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] rnd_row();
        logic [AW-1:0] r;
        for (int i = 0; i < AS; i++) begin
            case ($urandom_range(0, 5))
                0:       r[i*DW +: DW] = 8'h80;
                1:       r[i*DW +: DW] = 8'h00;
                2:       r[i*DW +: DW] = 8'h7F;
                default: r[i*DW +: DW] = 8'($urandom);
            endcase
        end
        return r;
    endfunction

    function automatic logic ready_pat(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: scoreboard pops on output handshakes, pushes on input accepts
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("stall_valid", AW'(out_valid), AW'(1));
                check("stall_data", out_data, stall_data);
                check("stall_last", AW'(out_last), AW'(stall_last));
            end
            if (out_valid && !out_ready) check("in_ready_stalled", AW'(in_ready), AW'(0));
            if (!cur_cfg) check("relu_en_bypass", AW'(relu_en), AW'(0));
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_row actual=%h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", AW'(out_last), AW'(e.last));
                    if (chk_lat) check("latency", AW'(cyc - e.cyc), AW'(1));
                end
            end
            stall      = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
            if (in_valid && in_ready) begin
                check("relu_en_run", AW'(relu_en), AW'(cur_cfg));
                exp_q.push_back('{exp_row(in_data, cur_cfg), (acc_idx == cur_rows - 1), cyc});
                acc_idx++;
                last_acc_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_layer(input int n, input logic cfg, input int mode, input logic inj);
        int d0;
        int h0;
        int b;
        d0       = done_cnt;
        h0       = hs_cnt;
        cur_rows = n;
        cur_cfg  = cfg;
        acc_idx  = 0;
        chk_lat  = (mode == 0);
        start    = 1'b1;
        num_rows = CW'(n);
        relu_cfg = cfg;
        out_ready = ready_pat(mode);
        tick();
        start    = 1'b0;
        num_rows = CW'($urandom);
        relu_cfg = 1'($urandom);
        check("busy_after_start", AW'(busy), AW'(1));
        b = 0;
        while (acc_idx < n && b < 2000) begin
            in_valid  = (mode != 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_data   = (acc_idx < dir_q.size()) ? dir_q[acc_idx] : rnd_row();
            out_ready = ready_pat(mode);
            start     = inj && (acc_idx == 1);
            if (start) num_rows = CW'(7);
            b++;
            tick();
        end
        if (b >= 2000) begin
            total++;
            bad++;
            $display("FAIL feed_timeout actual=%0d required=%0d", acc_idx, n);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        b = 0;
        while (done_cnt == d0 && b < 200) begin
            out_ready = ready_pat(mode);
            b++;
            tick();
        end
        check("done_seen", AW'(done_cnt - d0), AW'(1));
        check("busy_after_done", AW'(busy), AW'(0));
        if (mode == 0) check("done_gap", AW'(done_cyc - last_acc_cyc), AW'(2));
        out_ready = 1'b1;
        repeat (3) tick();
        check("done_once", AW'(done_cnt - d0), AW'(1));
        check("row_count", AW'(hs_cnt - h0), AW'(n));
        check("queue_empty", AW'(exp_q.size()), AW'(0));
        dir_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, AW'(busy), AW'(0));
        check({tag, "_done"}, AW'(done), AW'(0));
        check({tag, "_in_ready"}, AW'(in_ready), AW'(0));
        check({tag, "_relu_en"}, AW'(relu_en), AW'(0));
        check({tag, "_out_valid"}, AW'(out_valid), AW'(0));
        check({tag, "_out_last"}, AW'(out_last), AW'(0));
        check({tag, "_out_data"}, out_data, AW'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int d0;
        int b;
        reset = 1'b1; start = 1'b0; num_rows = '0; relu_cfg = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        check_zero_outputs("reset");
        in_valid = 1'b0;
        reset = 1'b0;
        tick();

        // basic flow with ReLU
        dir_q = '{ {56'h0, 8'd5}, {56'h0, 8'hFD}, {56'h0, 8'd127} };
        run_layer(3, 1'b1, 0, 1'b0);

        // bypass: negative extreme passes untouched
        dir_q = '{ {56'h123456789ABCDE, 8'h80}, {56'h0, 8'h7F} };
        run_layer(2, 1'b0, 0, 1'b0);

        // backpressure with out_ready 1,0,0,1 pattern
        run_layer(4, 1'b1, 1, 1'b0);

        // zero-row command
        d0 = done_cnt;
        cur_rows = 0;
        cur_cfg = 1'($urandom);
        start = 1'b1; num_rows = '0; relu_cfg = cur_cfg;
        tick();
        start = 1'b0;
        check("zero_done", AW'(done), AW'(1));
        check("zero_busy", AW'(busy), AW'(1));
        check("zero_out_valid", AW'(out_valid), AW'(0));
        tick();
        check("zero_done_after", AW'(done), AW'(0));
        check("zero_busy_after", AW'(busy), AW'(0));
        check("zero_done_count", AW'(done_cnt - d0), AW'(1));

        // reset in the middle of a layer
        cur_rows = 5; cur_cfg = 1'b1; acc_idx = 0; chk_lat = 1'b0;
        start = 1'b1; num_rows = CW'(5); relu_cfg = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        b = 0;
        while (acc_idx < 2 && b < 100) begin
            in_valid = 1'b1;
            in_data = rnd_row();
            b++;
            tick();
        end
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        check_zero_outputs("midreset");
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        check("midreset_no_done", AW'(done_cnt - d0), AW'(0));
        run_layer(1, 1'b1, 0, 1'b0);

        // second start while running is ignored
        run_layer(3, 1'b1, 0, 1'b1);

        // randomized layers
        for (int k = 0; k < 10; k++) begin
            run_layer($urandom_range(1, 12), 1'($urandom_range(0, 1)), (k % 2) + 1, (k == 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
